seq_divider: RTL and testbench

- Multi-cycle 64-bit integer divider for the execute stage; implements UDIV/SDIV.
- Produces quotient and remainder; remainder is for MSUB-based modulo sequences.
- Built on the same subtract datapath style as the ALU add/subtract path.
- Uses one restoring-division step per cycle; the pipeline stalls on busy and resumes on done.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/seq_divider_div_step.sv | 22 ++
 rtl/seq_divider.sv | 106 ++++++++++
 tb/tb_seq_divider.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared divider types, width constant and two's-complement helper
package cpu_pkg;
   localparam int DATA_WIDTH = 64;
   typedef enum logic [1:0] {IDLE, CALC, FIN} div_state_t;
   function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] v);
      return ~v + 1'b1;
   endfunction
endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring-division iteration on the {rem,quo} pair
module div_step
   import cpu_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor_mag,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
   // a borrow out of the WIDTH+1-bit subtract means the divisor did not fit
   always_comb begin
      shifted  = {rem, quo[WIDTH-1]};
      trial    = shifted - {1'b0, divisor_mag};
      rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
   end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for UDIV/SDIV with quotient and remainder
module seq_divider
   import cpu_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   div_state_t       state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem, quo, dvs, rem_n, quo_n;
   logic             q_neg, r_neg, accept, dvd_neg, dvs_neg;

   assign accept  = start && !flush;
   assign dvd_neg = is_signed && dividend[WIDTH-1];
   assign dvs_neg = is_signed && divisor[WIDTH-1];

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem(rem),
      .quo(quo),
      .divisor_mag(dvs),
      .rem_next(rem_n),
      .quo_next(quo_n)
   );

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // next state: zero divisor bypasses the iterations, flush aborts to idle
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = accept ? ((divisor == '0) ? FIN : CALC) : IDLE;
         CALC:    state_next = flush ? IDLE : ((cnt == CNT_W'(1)) ? FIN : CALC);
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // operand capture, iteration datapath and result registration
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         rem       <= '0;
         quo       <= '0;
         dvs       <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               busy <= 1'b1;
               cnt  <= CNT_W'(WIDTH);
               if (divisor == '0) begin
                  rem   <= dividend;
                  quo   <= '0;
                  dvs   <= '0;
                  q_neg <= 1'b0;
                  r_neg <= 1'b0;
               end else begin
                  rem   <= '0;
                  quo   <= dvd_neg ? negate(dividend) : dividend;
                  dvs   <= dvs_neg ? negate(divisor) : divisor;
                  q_neg <= dvd_neg ^ dvs_neg;
                  r_neg <= dvd_neg;
               end
            end
            CALC: if (flush) begin
               busy <= 1'b0;
            end else begin
               rem <= rem_n;
               quo <= quo_n;
               cnt <= cnt - 1'b1;
            end
            FIN: begin
               busy <= 1'b0;
               if (!flush) begin
                  done      <= 1'b1;
                  quotient  <= q_neg ? negate(quo) : quo;
                  remainder <= r_neg ? negate(rem) : rem;
               end
            end
            default: busy <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors checked against a latency/arithmetic model of the divider
module tb_seq_divider;
   logic        clk = 1'b0, reset = 1'b0, start = 1'b0, is_signed = 1'b0, flush = 1'b0;
   logic [63:0] dividend = '0, divisor = '0;
   logic        busy, done;
   logic [63:0] quotient, remainder;
   int          errors = 0, checks = 0;
   logic        cmp_on = 1'b0;

   logic        m_busy = 1'b0, m_done = 1'b0;
   logic [63:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
   int          m_left = 0;

   seq_divider dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .is_signed(is_signed),
      .dividend(dividend),
      .divisor(divisor),
      .flush(flush),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder)
   );

   always #5 clk = ~clk;

   // Arithmetic reference: truncating division, remainder takes the dividend's sign
   function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                                   output logic [63:0] q, output logic [63:0] r);
      logic [63:0] ma, mb;
      if (b == 0) begin
         q = 0;
         r = a;
      end else if (!sgn) begin
         q = a / b;
         r = a % b;
      end else begin
         ma = a[63] ? -a : a;
         mb = b[63] ? -b : b;
         q = ma / mb;
         r = ma % mb;
         if (a[63] ^ b[63]) q = -q;
         if (a[63]) r = -r;
      end
   endfunction

   // Model: a result arrives 65 edges after acceptance (1 for a zero divisor)
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy = 0; m_done = 0; m_q = 0; m_r = 0; m_left = 0;
      end else begin
         m_done = 0;
         if (m_left > 0) begin
            if (flush) begin
               m_left = 0;
               m_busy = 0;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_done = 1; m_busy = 0; m_q = p_q; m_r = p_r;
               end
            end
         end else if (start && !flush) begin
            ref_div(dividend, divisor, is_signed, p_q, p_r);
            m_left = (divisor == 0) ? 1 : 65;
            m_busy = 1;
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) if (cmp_on) begin
      checks++;
      if ({busy, done, quotient, remainder} !== {m_busy, m_done, m_q, m_r}) begin
         errors++;
         $display("FAIL cycle_cmp @%0t: got busy=%b done=%b q=%h r=%h expected busy=%b done=%b q=%h r=%h",
                  $time, busy, done, quotient, remainder, m_busy, m_done, m_q, m_r);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic go(input logic [63:0] a, input logic [63:0] b, input logic sgn);
      dividend = a; divisor = b; is_signed = sgn; start = 1'b1;
   endtask

   task automatic run_div(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic sgn, input logic [63:0] eq, input logic [63:0] er,
                          input int elat);
      int k;
      go(a, b, sgn);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk({name, " latency"}, 64'(k), 64'(elat));
      chk({name, " quotient"}, quotient, eq);
      chk({name, " remainder"}, remainder, er);
   endtask

   initial begin
      int  k;
      logic saw_done;
      repeat (2) @(negedge clk);
      chk("reset busy", 64'(busy), 64'(0));
      chk("reset done", 64'(done), 64'(0));
      chk("reset quotient", quotient, 64'h0);
      chk("reset remainder", remainder, 64'h0);
      reset = 1'b1;
      cmp_on = 1'b1;
      @(negedge clk);

      run_div("udiv 100/7", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 65);
      run_div("sdiv -100/7", -64'sd100, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      run_div("sdiv 100/-7", 64'd100, -64'sd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 65);
      run_div("udiv by zero", 64'h1234, 64'h0, 1'b0, 64'h0, 64'h1234, 1);
      run_div("sdiv by zero", 64'h1234, 64'h0, 1'b1, 64'h0, 64'h1234, 1);
      run_div("sdiv intmin/-1", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              64'h8000_0000_0000_0000, 64'h0, 65);
      run_div("udiv ones/1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 65);

      // start while busy is ignored
      go(64'd100, 64'd7, 1'b0);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (k < 10) begin @(negedge clk); k++; end
      go(64'd9, 64'd3, 1'b0);
      @(negedge clk);
      k++;
      start = 1'b0;
      while (k < 65) begin @(negedge clk); k++; end
      chk("busy-start done", 64'(done), 64'(1));
      chk("busy-start quotient", quotient, 64'd14);
      chk("busy-start remainder", remainder, 64'd2);
      // start the cycle right after done is accepted
      run_div("after done 9/3", 64'd9, 64'd3, 1'b0, 64'd3, 64'd0, 65);

      // start sampled on the done edge (state FIN) is ignored
      @(negedge clk);
      go(64'd100, 64'd7, 1'b0);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (k < 64) begin @(negedge clk); k++; end
      go(64'd9, 64'd3, 1'b0);
      @(negedge clk);
      start = 1'b0;
      chk("fin-start done", 64'(done), 64'(1));
      chk("fin-start quotient", quotient, 64'd14);
      @(negedge clk);
      chk("fin-start not accepted", 64'(busy), 64'(0));

      // flush mid-calculation
      go(64'd100, 64'd3, 1'b0);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (k < 20) begin @(negedge clk); k++; end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush busy cleared", 64'(busy), 64'(0));
      saw_done = 1'b0;
      repeat (70) begin
         @(negedge clk);
         saw_done |= done;
      end
      chk("flush no done", 64'(saw_done), 64'(0));
      chk("flush quotient held", quotient, 64'd14);
      chk("flush remainder held", remainder, 64'd2);

      // flush wins over start in idle
      go(64'd100, 64'd7, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      chk("flush vs start", 64'(busy), 64'(0));

      // asynchronous reset mid-operation
      go(64'd100, 64'd7, 1'b0);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (k < 30) begin @(negedge clk); k++; end
      #2 reset = 1'b0;
      #1;
      chk("async reset busy", 64'(busy), 64'(0));
      chk("async reset done", 64'(done), 64'(0));
      chk("async reset quotient", quotient, 64'h0);
      chk("async reset remainder", remainder, 64'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_div("post-reset 1000/33", 64'd1000, 64'd33, 1'b0, 64'd30, 64'd10, 65);

      @(negedge clk);
      cmp_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
